// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter merging instruction fetch and data requests
//
// Purpose:
//   Serialises instruction-fetch (iREN) and data (dREN/dWEN) requests onto one
//   variable-latency RAM port. Data requests take priority over instruction
//   requests. Every access runs IDLE -> IACC/DACC -> RESP -> IDLE, and the
//   arbiter accepts at most one access every three cycles.
//
// Parameters:
//   ADDR_W   address width
//   DATA_W   data word width
//   PERF_W   performance counter width (only with MEM_ARB_PERF_EN)
//
// Ports:
//   CLK, nRST                  clock (rising edge), asynchronous active-low reset
//   iREN, iaddr                instruction read request, held until ihit
//   dREN, dWEN, daddr, dstore  data read/write request, held until dhit
//   ihit, dhit                 one-cycle completion pulses
//   iload, dload               last fetched instruction / loaded data word
//   ramREN, ramWEN             RAM read/write enables
//   ramaddr, ramstore          word-aligned RAM address and write data
//   ramload, ram_ack           RAM read data and one-cycle completion pulse
//   perf_iacc, perf_dacc,      completed-access and RAM wait-cycle counters
//   perf_wait                  (present only when MEM_ARB_PERF_EN is defined)
//
// Optional feature macro: MEM_ARB_PERF_EN

module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int PERF_W = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              ihit,
    output logic              dhit,
    output logic [DATA_W-1:0] iload,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
`ifdef MEM_ARB_PERF_EN
    output logic [PERF_W-1:0] perf_iacc,
    output logic [PERF_W-1:0] perf_dacc,
    output logic [PERF_W-1:0] perf_wait,
`endif
    input  logic              ram_ack
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] IACC = 2'd1;
    localparam logic [1:0] DACC = 2'd2;
    localparam logic [1:0] RESP = 2'd3;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic [1:0] state;

    // The registered RAM outputs double as the captured request: ramaddr,
    // ramstore and ramWEN are loaded once in IDLE and held until ram_ack,
    // so requester inputs changing mid-access have no effect.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            ihit     <= 1'b0;
            dhit     <= 1'b0;
            iload    <= '0;
            dload    <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
            ramaddr  <= '0;
            ramstore <= '0;
        end else begin
            ihit <= 1'b0;
            dhit <= 1'b0;
            case (state)
                IDLE: begin
                    if (dREN || dWEN) begin
                        state    <= DACC;
                        ramaddr  <= daddr & WORD_MASK;
                        ramstore <= dstore;
                        ramWEN   <= dWEN;
                        ramREN   <= !dWEN;
                    end else if (iREN) begin
                        state   <= IACC;
                        ramaddr <= iaddr & WORD_MASK;
                        ramREN  <= 1'b1;
                        ramWEN  <= 1'b0;
                    end
                end
                IACC: begin
                    if (ram_ack) begin
                        state  <= RESP;
                        ramREN <= 1'b0;
                        iload  <= ramload;
                        // A fetch withdrawn during the access (flush) still
                        // updates iload but must not report a hit.
                        ihit   <= iREN;
                    end
                end
                DACC: begin
                    if (ram_ack) begin
                        state  <= RESP;
                        ramREN <= 1'b0;
                        ramWEN <= 1'b0;
                        dhit   <= 1'b1;
                        if (ramREN) begin
                            dload <= ramload;
                        end
                    end
                end
                // One dead cycle while the hit pulse is visible, so the
                // requester's still-high enable is never re-accepted.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            perf_iacc <= '0;
            perf_dacc <= '0;
            perf_wait <= '0;
        end else begin
            if (state == IACC && ram_ack) begin
                perf_iacc <= perf_iacc + 1'b1;
            end
            if (state == DACC && ram_ack) begin
                perf_dacc <= perf_dacc + 1'b1;
            end
            if ((state == IACC || state == DACC) && !ram_ack) begin
                perf_wait <= perf_wait + 1'b1;
            end
        end
    end
`endif

endmodule
